// File: rtl/wino_pkg.sv
// Shared types and constants for the weight store and its controller-facing interface.
package wino_pkg;
    localparam int LANES = 18;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int LW    = 5;

    // One weight row; row[k] is lane k.
    typedef logic [LANES-1:0][DW-1:0] weight_row_t;

    typedef enum logic [1:0] {IDLE, READ, DONE} wmem_state_t;
endpackage

// File: rtl/weight_mem_responder_if.sv
// Fetch and load signals between the weight controller/loader and the weight store.
interface weight_mem_responder_if
    import wino_pkg::*;
    ();
    logic              load_wen_i;
    logic [AW-1:0]     load_addr_i;
    logic [LW-1:0]     load_lane_i;
    logic [DW-1:0]     load_data_i;
    logic [AW-1:0]     weight_addr_i;
    logic              weight_request_i;
    logic [DW-1:0]     weight_data_o [LANES-1:0];
    logic              weight_valid_o;
    logic              addr_err_o;
    logic              busy_o;
    wmem_state_t       state;

    // weight_request_i is a level; weight_valid_o pulses once per latched address and
    // weight_data_o is valid on that cycle and held until the next read completes.
    modport master (
        output load_wen_i, load_addr_i, load_lane_i, load_data_i,
        output weight_addr_i, weight_request_i,
        input  weight_data_o, weight_valid_o, addr_err_o, busy_o, state
    );
    modport slave (
        input  load_wen_i, load_addr_i, load_lane_i, load_data_i,
        input  weight_addr_i, weight_request_i,
        output weight_data_o, weight_valid_o, addr_err_o, busy_o, state
    );
endinterface

// File: rtl/weight_bank.sv
// Row storage with per-element writes and a registered whole-row read.
module weight_bank
    import wino_pkg::*;
#(
    parameter  int DEPTH = 256,
    localparam int RW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [RW-1:0] wr_row,
    input  logic [LW-1:0] wr_lane,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic          rd_zero,
    input  logic [RW-1:0] rd_row,
    output weight_row_t   rd_data
);
    weight_row_t mem [DEPTH];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_row][wr_lane] <= wr_data;
    end

    // Same-edge write to the row being read returns the old row.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_row];
        end
    end
endmodule

// File: rtl/weight_mem_responder.sv
// Weight store answering the controller's request/valid fetch protocol, with a load port.
module weight_mem_responder
    import wino_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    weight_mem_responder_if.slave  bus
);
    localparam int RW = $clog2(DEPTH);

    wmem_state_t   state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          valid_q;
    logic          err_q;
    logic          rd_in_range;
    logic          load_ok;
    logic          load_bad;
    weight_row_t   row_q;

    assign rd_in_range = (32'(addr_q) < DEPTH);
    assign load_ok     = (32'(bus.load_addr_i) < DEPTH) && (32'(bus.load_lane_i) < LANES);
    assign load_bad    = bus.load_wen_i && !load_ok;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.weight_request_i) begin
                    addr_d  = bus.weight_addr_i;
                    state_d = READ;
                end
            end
            READ: state_d = DONE;
            DONE: begin
                if (!bus.weight_request_i) begin
                    state_d = IDLE;
                end else if (bus.weight_addr_i != addr_q) begin
                    addr_d  = bus.weight_addr_i;
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= (state_q == READ);
            if ((state_q == READ && !rd_in_range) || load_bad) err_q <= 1'b1;
        end
    end

    weight_bank #(.DEPTH(DEPTH)) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bus.load_wen_i && load_ok),
        .wr_row  (bus.load_addr_i[RW-1:0]),
        .wr_lane (bus.load_lane_i),
        .wr_data (bus.load_data_i),
        .rd_en   (state_q == READ),
        .rd_zero (!rd_in_range),
        .rd_row  (addr_q[RW-1:0]),
        .rd_data (row_q)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign bus.weight_data_o[k] = row_q[k];
    end

    assign bus.weight_valid_o = valid_q;
    assign bus.addr_err_o     = err_q;
    assign bus.busy_o         = (state_q != IDLE);
    assign bus.state          = state_q;
endmodule

// File: tb/tb_weight_mem_responder.sv
// Directed plus randomized checks of the weight store against a row-array reference model.
module tb_weight_mem_responder;
  import wino_pkg::*;

  localparam int DEPTH = 256;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  weight_mem_responder_if bus ();

  weight_mem_responder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // reference model: row contents and sticky error flag
  weight_row_t ref_mem [DEPTH];
  logic        exp_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic weight_row_t exp_row(input logic [15:0] a);
    if (int'(a) < DEPTH) return ref_mem[a[7:0]];
    return '0;
  endfunction

  task automatic chk_row(input string tag, input weight_row_t exp);
    for (int k = 0; k < LANES; k++) chk(tag, 32'(bus.weight_data_o[k]), 32'(exp[k]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.weight_request_i = 1'b0;
    bus.load_wen_i = 1'b0;
    step();
    step();
    reset = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] a, input logic [4:0] l, input logic [15:0] d);
    bus.load_wen_i  = 1'b1;
    bus.load_addr_i = a;
    bus.load_lane_i = l;
    bus.load_data_i = d;
    step();
    bus.load_wen_i  = 1'b0;
    if (int'(a) < DEPTH && int'(l) < LANES) ref_mem[a[7:0]][l] = d;
    else exp_err = 1'b1;
  endtask

  // full fetch: request, wait for the pulse, check it is single, then release
  task automatic do_read(input string tag, input logic [15:0] a);
    weight_row_t er;
    int lat;
    bit seen;
    er = exp_row(a);
    bus.weight_addr_i = a;
    bus.weight_request_i = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 6) begin
      step();
      lat++;
      if (bus.weight_valid_o === 1'b1) seen = 1'b1;
    end
    chk({tag, "_valid"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    chk_row({tag, "_data"}, er);
    if (int'(a) >= DEPTH) exp_err = 1'b1;
    chk({tag, "_err"}, 32'(bus.addr_err_o), 32'(exp_err));
    step();
    chk({tag, "_nodup"}, 32'(bus.weight_valid_o), 32'd0);
    chk({tag, "_busy_hold"}, 32'(bus.busy_o), 32'd1);
    bus.weight_request_i = 1'b0;
    step();
    chk({tag, "_busy_rel"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_data_hold"}, 32'(bus.weight_data_o[0]), 32'(er[0]));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_err = 1'b0;
    for (int r = 0; r < DEPTH; r++) ref_mem[r] = '0;
    bus.load_wen_i = 1'b0;
    bus.load_addr_i = '0;
    bus.load_lane_i = '0;
    bus.load_data_i = '0;
    bus.weight_addr_i = '0;
    bus.weight_request_i = 1'b0;

    // reset state
    do_reset();
    chk("rst_valid", 32'(bus.weight_valid_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_err", 32'(bus.addr_err_o), 32'd0);
    chk("rst_state", 32'(bus.state), 32'(IDLE));
    chk_row("rst_data", '0);

    // random preload of rows 0..15, plus known rows 5, 7, 9
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < LANES; k++) do_load(16'(r), 5'(k), 16'($urandom_range(0, 65535)));
    for (int k = 0; k < LANES; k++) begin
      do_load(16'd5, 5'(k), 16'(16'h0100 + k));
      do_load(16'd7, 5'(k), 16'(16'h0700 + k));
    end
    do_load(16'd9, 5'd4, 16'h1111);

    // single pulse, 2-cycle latency, busy until release
    do_read("t1", 16'd5);

    // address change while held in DONE
    bus.weight_addr_i = 16'd5;
    bus.weight_request_i = 1'b1;
    step();
    step();
    chk("t2_valid5", 32'(bus.weight_valid_o), 32'd1);
    chk("t2_d5", 32'(bus.weight_data_o[3]), 32'h0103);
    step();
    chk("t2_nodup5", 32'(bus.weight_valid_o), 32'd0);
    chk("t2_state_done", 32'(bus.state), 32'(DONE));
    bus.weight_addr_i = 16'd7;
    step();
    chk("t2_wait7", 32'(bus.weight_valid_o), 32'd0);
    step();
    chk("t2_valid7", 32'(bus.weight_valid_o), 32'd1);
    chk("t2_d7", 32'(bus.weight_data_o[3]), 32'h0703);
    step();
    chk("t2_nodup7", 32'(bus.weight_valid_o), 32'd0);
    bus.weight_request_i = 1'b0;
    step();
    step();

    // out-of-range read: zero row, pulse, sticky error
    do_read("t3", 16'd300);
    step();
    chk("t3_err_sticky", 32'(bus.addr_err_o), 32'd1);

    // bad lane write is dropped and flags error
    do_reset();
    chk("t4_err_clr", 32'(bus.addr_err_o), 32'd0);
    do_load(16'd2, 5'd18, 16'hdead);
    step();
    chk("t4_err_lane", 32'(bus.addr_err_o), 32'd1);
    do_read("t4_rd2", 16'd2);
    do_reset();
    do_load(16'd256, 5'd0, 16'hbeef);
    step();
    chk("t4_err_row", 32'(bus.addr_err_o), 32'd1);
    do_read("t4_rd0", 16'd0);

    // read-before-write collision on row 9
    bus.weight_addr_i = 16'd9;
    bus.weight_request_i = 1'b1;
    step();
    chk("t5_state_read", 32'(bus.state), 32'(READ));
    bus.load_wen_i  = 1'b1;
    bus.load_addr_i = 16'd9;
    bus.load_lane_i = 5'd4;
    bus.load_data_i = 16'h2222;
    step();
    bus.load_wen_i  = 1'b0;
    chk("t5_valid", 32'(bus.weight_valid_o), 32'd1);
    chk("t5_old", 32'(bus.weight_data_o[4]), 32'h1111);
    ref_mem[9][4] = 16'h2222;
    bus.weight_request_i = 1'b0;
    step();
    step();
    do_read("t5_new", 16'd9);
    chk("t5_new4", 32'(bus.weight_data_o[4]), 32'h2222);

    // reset during READ abandons the read
    bus.weight_addr_i = 16'd5;
    bus.weight_request_i = 1'b1;
    step();
    chk("t6_in_read", 32'(bus.state), 32'(READ));
    reset = 1'b1;
    bus.weight_request_i = 1'b0;
    step();
    chk("t6_valid", 32'(bus.weight_valid_o), 32'd0);
    chk("t6_state", 32'(bus.state), 32'(IDLE));
    chk("t6_busy", 32'(bus.busy_o), 32'd0);
    chk_row("t6_data", '0);
    reset = 1'b0;
    exp_err = 1'b0;
    step();
    chk("t6_valid_after", 32'(bus.weight_valid_o), 32'd0);
    do_read("t6_rd5", 16'd5);

    // randomized mix of loads and reads against the model
    for (int n = 0; n < 60; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 5) begin
        do_load(16'($urandom_range(0, 15)), 5'($urandom_range(0, 17)), 16'($urandom_range(0, 65535)));
      end else if (op == 5) begin
        do_load(16'($urandom_range(250, 600)), 5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)));
        step();
        chk("rnd_load_err", 32'(bus.addr_err_o), 32'(exp_err));
      end else if (op < 9) begin
        do_read("rnd_rd", 16'($urandom_range(0, 15)));
      end else begin
        do_read("rnd_oor", 16'($urandom_range(256, 65535)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
